// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute payload, runs at most one
// data-SRAM transaction per instruction, aligns load data and forwards results.
`timescale 1ns/1ps

module mem_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         EX_to_MEM,
    input  logic [145:0] EX_to_MEM_zip,
    input  logic [86:0]  EX_except_zip,
    output logic         MEM_allowin,
    output logic         MEM_to_WB,
    output logic [103:0] MEM_to_WB_zip,
    output logic [86:0]  MEM_except_zip,
    input  logic         WB_allowin,
    input  logic         flush,
    output logic         front_valid,
    output logic [4:0]   front_addr,
    output logic [31:0]  front_data,
    output logic         MEM_is_load,
    output logic         MEM_is_csr,
    output logic         data_sram_req,
    output logic         data_sram_wr,
    output logic [1:0]   data_sram_size,
    output logic [3:0]   data_sram_wstrb,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    input  logic         data_sram_addr_ok,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          at_state_q, at_state_d;
    logic [145:0]  zip_q, zip_d;
    logic [86:0]   except_q, except_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          zip_valid, ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w;
    logic          mem_we, res_from_mem, gr_we, is_csr;
    logic [31:0]   pc, ir, rkd_value, compute_result;
    logic [4:0]    rf_waddr;
    logic [1:0]    off;

    assign zip_valid      = zip_q[145];
    assign pc             = zip_q[144:113];
    assign ir             = zip_q[112:81];
    assign ld_b           = zip_q[80];
    assign ld_bu          = zip_q[79];
    assign ld_h           = zip_q[78];
    assign ld_hu          = zip_q[77];
    assign ld_w           = zip_q[76];
    assign st_b           = zip_q[75];
    assign st_h           = zip_q[74];
    assign st_w           = zip_q[73];
    assign mem_we         = zip_q[72];
    assign res_from_mem   = zip_q[71];
    assign gr_we          = zip_q[70];
    assign rkd_value      = zip_q[69:38];
    assign rf_waddr       = zip_q[37:33];
    assign compute_result = zip_q[32:1];
    assign is_csr         = zip_q[0];
    assign off            = compute_result[1:0];

    logic valid, mem_op, readygo;
    logic [31:0] shifted, load_data, final_result;

    assign valid   = at_state_q & zip_valid & ~flush;
    // A misaligned access is passed to write-back as an exception, never issued.
    assign mem_op  = valid & (res_from_mem | mem_we) & ~except_q[0];
    assign readygo = valid & ((state_q == S_DONE) | ((state_q == S_REQ) & ~mem_op));

    assign MEM_to_WB   = readygo & WB_allowin;
    assign MEM_allowin = (~valid | MEM_to_WB) & (state_q != S_DRAIN);

    // SRAM handshake: req with addr/size/wstrb/wdata is held stable until the
    // cycle addr_ok is seen with req high; the response arrives later as a
    // single-cycle data_ok. Only one transaction is ever outstanding.
    assign data_sram_req   = (state_q == S_REQ) & mem_op & ~flush;
    assign data_sram_wr    = mem_we;
    assign data_sram_addr  = compute_result;

    always_comb begin
        data_sram_size = 2'd2;
        if (ld_w | st_w)
            data_sram_size = 2'd2;
        else if (ld_h | ld_hu | st_h)
            data_sram_size = 2'd1;
        else if (ld_b | ld_bu | st_b)
            data_sram_size = 2'd0;
    end

    always_comb begin
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = rkd_value;
        if (st_b) begin
            data_sram_wstrb = 4'b0001 << off;
            data_sram_wdata = {4{rkd_value[7:0]}};
        end else if (st_h) begin
            data_sram_wstrb = off[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{rkd_value[15:0]}};
        end else if (st_w) begin
            data_sram_wstrb = 4'b1111;
        end
    end

    assign shifted = rdata_q >> {off, 3'b000};

    always_comb begin
        load_data = rdata_q;
        if (ld_b)
            load_data = {{24{shifted[7]}}, shifted[7:0]};
        else if (ld_bu)
            load_data = {24'd0, shifted[7:0]};
        else if (ld_h)
            load_data = {{16{shifted[15]}}, shifted[15:0]};
        else if (ld_hu)
            load_data = {16'd0, shifted[15:0]};
    end

    assign final_result   = res_from_mem ? load_data : compute_result;
    assign MEM_to_WB_zip  = {valid & ~rst, pc, ir, gr_we, rf_waddr, final_result, is_csr};
    assign MEM_except_zip = except_q;

    assign front_valid = valid & gr_we & (~res_from_mem | (state_q == S_DONE));
    assign front_addr  = rf_waddr;
    assign front_data  = final_result;
    assign MEM_is_load = valid & res_from_mem & (state_q != S_DONE);
    assign MEM_is_csr  = valid & is_csr;
    assign dbg_state   = state_q;

    always_comb begin
        zip_d    = EX_to_MEM ? EX_to_MEM_zip : zip_q;
        except_d = EX_to_MEM ? EX_except_zip : except_q;
        rdata_d  = ((state_q == S_WAIT) && data_sram_data_ok && !flush) ? data_sram_rdata : rdata_q;
        if (flush)
            at_state_d = 1'b0;
        else if (EX_to_MEM)
            at_state_d = 1'b1;
        else if (MEM_to_WB)
            at_state_d = 1'b0;
        else
            at_state_d = at_state_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:
                if (EX_to_MEM && !flush) state_d = S_REQ;
            S_REQ:
                if (flush)
                    state_d = S_IDLE;
                else if (!mem_op) begin
                    // Non-memory work can leave straight from REQ if WB is ready.
                    if (MEM_to_WB) state_d = EX_to_MEM ? S_REQ : S_IDLE;
                    else           state_d = S_DONE;
                end else if (data_sram_req && data_sram_addr_ok)
                    state_d = S_WAIT;
            S_WAIT:
                if (data_sram_data_ok)
                    state_d = flush ? S_IDLE : S_DONE;
                else if (flush)
                    state_d = S_DRAIN;
            S_DONE:
                if (flush)
                    state_d = S_IDLE;
                else if (MEM_to_WB || !valid)
                    state_d = EX_to_MEM ? S_REQ : S_IDLE;
            S_DRAIN:
                if (data_sram_data_ok) state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            at_state_q <= 1'b0;
            zip_q      <= '0;
            except_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            at_state_q <= at_state_d;
            zip_q      <= zip_d;
            except_q   <= except_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, misaligned pass-through,
// flush/drain, reset mid-transaction and write-back backpressure.
`timescale 1ns/1ps

module tb_mem_stage;

    localparam logic [31:0] PC_C = 32'h1c00_0100;
    localparam logic [31:0] IR_C = 32'h2880_0000;
    localparam logic [4:0]  LD_W = 5'b00001, LD_B = 5'b10000, LD_BU = 5'b01000, LD_H = 5'b00100;
    localparam logic [2:0]  ST_H = 3'b010, ST_B = 3'b100, ST_NONE = 3'b000;
    localparam logic [2:0]  ST_DRAIN_ENC = 3'd4;

    logic         clk = 1'b0;
    logic         rst;
    logic         EX_to_MEM;
    logic [145:0] EX_to_MEM_zip;
    logic [86:0]  EX_except_zip;
    logic         MEM_allowin, MEM_to_WB;
    logic [103:0] MEM_to_WB_zip;
    logic [86:0]  MEM_except_zip;
    logic         WB_allowin, flush;
    logic         front_valid;
    logic [4:0]   front_addr;
    logic [31:0]  front_data;
    logic         MEM_is_load, MEM_is_csr;
    logic         data_sram_req, data_sram_wr;
    logic [1:0]   data_sram_size;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    logic         data_sram_addr_ok, data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .EX_to_MEM(EX_to_MEM), .EX_to_MEM_zip(EX_to_MEM_zip), .EX_except_zip(EX_except_zip),
        .MEM_allowin(MEM_allowin), .MEM_to_WB(MEM_to_WB), .MEM_to_WB_zip(MEM_to_WB_zip),
        .MEM_except_zip(MEM_except_zip), .WB_allowin(WB_allowin), .flush(flush),
        .front_valid(front_valid), .front_addr(front_addr), .front_data(front_data),
        .MEM_is_load(MEM_is_load), .MEM_is_csr(MEM_is_csr),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [145:0] mk(input logic [4:0] ld, input logic [2:0] st,
                                        input logic we, input logic rfm, input logic gwe,
                                        input logic [31:0] rkd, input logic [4:0] wa,
                                        input logic [31:0] cr, input logic csr);
        return {1'b1, PC_C, IR_C, ld, st, we, rfm, gwe, rkd, wa, cr, csr};
    endfunction

    // Latch a load, addr_ok in the first REQ cycle, data_ok the next, handoff on the third.
    task automatic run_load(input string tag, input logic [145:0] zip, input logic [31:0] rd,
                            input logic [31:0] exp, input logic [1:0] exp_size);
        EX_to_MEM = 1'b1; EX_to_MEM_zip = zip; EX_except_zip = '0;
        settle();
        check({tag, "_allowin_idle"}, MEM_allowin, 1'b1);
        next_cycle();
        EX_to_MEM = 1'b0; data_sram_addr_ok = 1'b1;
        settle();
        check({tag, "_req"}, data_sram_req, 1'b1);
        check({tag, "_addr"}, data_sram_addr, zip[32:1]);
        check({tag, "_size"}, data_sram_size, exp_size);
        check({tag, "_wr"}, data_sram_wr, 1'b0);
        check({tag, "_is_load"}, MEM_is_load, 1'b1);
        check({tag, "_no_fwd_yet"}, front_valid, 1'b0);
        check({tag, "_allowin_busy"}, MEM_allowin, 1'b0);
        next_cycle();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = rd;
        settle();
        check({tag, "_req_dropped"}, data_sram_req, 1'b0);
        check({tag, "_no_wb_in_wait"}, MEM_to_WB, 1'b0);
        next_cycle();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        settle();
        check({tag, "_to_wb"}, MEM_to_WB, 1'b1);
        check({tag, "_result"}, MEM_to_WB_zip[32:1], exp);
        check({tag, "_fwd_valid"}, front_valid, 1'b1);
        check({tag, "_fwd_data"}, front_data, exp);
        check({tag, "_is_load_done"}, MEM_is_load, 1'b0);
        next_cycle();
        settle();
        check({tag, "_wb_once"}, MEM_to_WB, 1'b0);
        check({tag, "_allowin_after"}, MEM_allowin, 1'b1);
        next_cycle();
    endtask

    // Store with addr_ok delayed one cycle so the held request is checked twice.
    task automatic run_store(input string tag, input logic [145:0] zip, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wdata, input logic [1:0] exp_size);
        EX_to_MEM = 1'b1; EX_to_MEM_zip = zip; EX_except_zip = '0;
        next_cycle();
        EX_to_MEM = 1'b0;
        for (int k = 0; k < 2; k++) begin
            data_sram_addr_ok = (k == 1);
            settle();
            check({tag, "_req"}, data_sram_req, 1'b1);
            check({tag, "_wstrb"}, data_sram_wstrb, exp_strb);
            check({tag, "_wdata"}, data_sram_wdata, exp_wdata);
            check({tag, "_size"}, data_sram_size, exp_size);
            check({tag, "_wr"}, data_sram_wr, 1'b1);
            check({tag, "_addr"}, data_sram_addr, zip[32:1]);
            next_cycle();
        end
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
        settle();
        check({tag, "_no_wb_in_wait"}, MEM_to_WB, 1'b0);
        next_cycle();
        data_sram_data_ok = 1'b0;
        settle();
        check({tag, "_to_wb"}, MEM_to_WB, 1'b1);
        check({tag, "_no_fwd"}, front_valid, 1'b0);
        next_cycle();
    endtask

    logic [145:0] z;
    logic [103:0] exp_wb;
    logic [86:0]  exc;

    initial begin
        rst = 1'b1; EX_to_MEM = 1'b0; EX_to_MEM_zip = '0; EX_except_zip = '0;
        WB_allowin = 1'b1; flush = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        next_cycle();
        next_cycle();
        settle();
        check("rst_allowin", MEM_allowin, 1'b1);
        check("rst_req", data_sram_req, 1'b0);
        check("rst_to_wb", MEM_to_WB, 1'b0);
        check("rst_fwd", front_valid, 1'b0);
        check("rst_is_load", MEM_is_load, 1'b0);
        check("rst_is_csr", MEM_is_csr, 1'b0);
        check("rst_wb_zip", MEM_to_WB_zip, 104'h0);
        check("rst_except", MEM_except_zip, 87'h0);
        check("rst_state", dbg_state, 3'd0);
        rst = 1'b0;
        next_cycle();

        run_load("ldw", mk(LD_W, ST_NONE, 1'b0, 1'b1, 1'b1, 32'h0, 5'd5, 32'h0000_1000, 1'b0),
                 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd2);
        run_load("ldb", mk(LD_B, ST_NONE, 1'b0, 1'b1, 1'b1, 32'h0, 5'd6, 32'h0000_1003, 1'b0),
                 32'h8011_2233, 32'hFFFF_FF80, 2'd0);
        run_load("ldbu", mk(LD_BU, ST_NONE, 1'b0, 1'b1, 1'b1, 32'h0, 5'd6, 32'h0000_1003, 1'b0),
                 32'h8011_2233, 32'h0000_0080, 2'd0);
        run_load("ldh", mk(LD_H, ST_NONE, 1'b0, 1'b1, 1'b1, 32'h0, 5'd7, 32'h0000_1002, 1'b0),
                 32'h8011_2233, 32'hFFFF_8011, 2'd1);

        run_store("sth", mk(5'b0, ST_H, 1'b1, 1'b0, 1'b0, 32'h0000_ABCD, 5'd0, 32'h0000_2002, 1'b0),
                  4'b1100, 32'hABCD_ABCD, 2'd1);
        run_store("stb", mk(5'b0, ST_B, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 5'd0, 32'h0000_2003, 1'b0),
                  4'b1000, 32'h7878_7878, 2'd0);

        // Misaligned ld.w: no request, handoff the cycle after latch, except passed through.
        exc = 87'h12_3456_789A_BCDE_F001;
        EX_to_MEM = 1'b1; EX_to_MEM_zip = mk(LD_W, ST_NONE, 1'b0, 1'b1, 1'b1, 32'h0, 5'd3, 32'h0000_1001, 1'b0);
        EX_except_zip = exc;
        next_cycle();
        EX_to_MEM = 1'b0; EX_except_zip = '0; data_sram_addr_ok = 1'b1;
        settle();
        check("ale_no_req", data_sram_req, 1'b0);
        check("ale_to_wb", MEM_to_WB, 1'b1);
        check("ale_except", MEM_except_zip, exc);
        next_cycle();
        data_sram_addr_ok = 1'b0;
        settle();
        check("ale_wb_once", MEM_to_WB, 1'b0);
        next_cycle();

        // Flush in REQ together with addr_ok: request gated, back to idle.
        EX_to_MEM = 1'b1; EX_to_MEM_zip = mk(LD_W, ST_NONE, 1'b0, 1'b1, 1'b1, 32'h0, 5'd4, 32'h0000_4000, 1'b0);
        next_cycle();
        EX_to_MEM = 1'b0; flush = 1'b1; data_sram_addr_ok = 1'b1;
        settle();
        check("flreq_req_gated", data_sram_req, 1'b0);
        next_cycle();
        flush = 1'b0; data_sram_addr_ok = 1'b0;
        settle();
        check("flreq_idle", dbg_state, 3'd0);
        check("flreq_allowin", MEM_allowin, 1'b1);
        check("flreq_no_wb", MEM_to_WB, 1'b0);
        next_cycle();

        // Flush in WAIT, data_ok arrives four cycles later.
        EX_to_MEM = 1'b1; EX_to_MEM_zip = mk(LD_W, ST_NONE, 1'b0, 1'b1, 1'b1, 32'h0, 5'd8, 32'h0000_3000, 1'b0);
        next_cycle();
        EX_to_MEM = 1'b0; data_sram_addr_ok = 1'b1;
        next_cycle();
        data_sram_addr_ok = 1'b0; flush = 1'b1;
        settle();
        check("flwait_no_wb", MEM_to_WB, 1'b0);
        next_cycle();
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data_sram_data_ok = (k == 3);
            data_sram_rdata = (k == 3) ? 32'h5555_AAAA : 32'h0;
            settle();
            check("drain_allowin", MEM_allowin, 1'b0);
            check("drain_no_req", data_sram_req, 1'b0);
            check("drain_no_wb", MEM_to_WB, 1'b0);
            check("drain_state", dbg_state, ST_DRAIN_ENC);
            next_cycle();
        end
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        settle();
        check("drain_exit_allowin", MEM_allowin, 1'b1);
        check("drain_exit_idle", dbg_state, 3'd0);
        check("drain_exit_no_wb", MEM_to_WB, 1'b0);
        next_cycle();

        // Reset during WAIT, then a stray data_ok must be ignored.
        EX_to_MEM = 1'b1; EX_to_MEM_zip = mk(LD_W, ST_NONE, 1'b0, 1'b1, 1'b1, 32'h0, 5'd9, 32'h0000_5000, 1'b0);
        next_cycle();
        EX_to_MEM = 1'b0; data_sram_addr_ok = 1'b1;
        next_cycle();
        data_sram_addr_ok = 1'b0; rst = 1'b1;
        next_cycle();
        rst = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_2222;
        settle();
        check("rstmid_idle", dbg_state, 3'd0);
        check("rstmid_allowin", MEM_allowin, 1'b1);
        next_cycle();
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        settle();
        check("stray_no_wb", MEM_to_WB, 1'b0);
        check("stray_no_fwd", front_valid, 1'b0);
        next_cycle();

        // ALU/CSR result held three cycles by write-back backpressure.
        z = mk(5'b0, ST_NONE, 1'b0, 1'b0, 1'b1, 32'h0, 5'd7, 32'h0000_0055, 1'b1);
        exp_wb = {1'b1, PC_C, IR_C, 1'b1, 5'd7, 32'h0000_0055, 1'b1};
        EX_to_MEM = 1'b1; EX_to_MEM_zip = z; WB_allowin = 1'b0;
        next_cycle();
        EX_to_MEM = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("hold_no_wb", MEM_to_WB, 1'b0);
            check("hold_zip", MEM_to_WB_zip, exp_wb);
            check("hold_fwd_valid", front_valid, 1'b1);
            check("hold_fwd_addr", front_addr, 5'd7);
            check("hold_fwd_data", front_data, 32'h0000_0055);
            check("hold_is_csr", MEM_is_csr, 1'b1);
            check("hold_allowin", MEM_allowin, 1'b0);
            next_cycle();
        end
        WB_allowin = 1'b1;
        settle();
        check("release_to_wb", MEM_to_WB, 1'b1);
        check("release_zip", MEM_to_WB_zip, exp_wb);
        next_cycle();
        settle();
        check("release_once", MEM_to_WB, 1'b0);
        check("release_fwd_off", front_valid, 1'b0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
